// File: rtl/cim_input_driver_if.sv
// Job, result and MAC-column signals of the bit-serial CIM input driver.
// The driver block uses the slave view; the job source/MAC environment uses master.
interface cim_input_driver_if #(
    parameter int IN_BITS = 8
);
    localparam int ACC_W = 15 + IN_BITS;

    logic                   in_valid;
    logic                   in_ready;
    logic [8*IN_BITS-1:0]   act;
    logic [7:0]             wsel;
    logic                   sus_in;

    logic [7:0]             rwlb_row0;
    logic [7:0]             rwlb_row1;
    logic                   sus;
    logic [14:0]            mac_out;

    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;

    modport slave (
        input  in_valid, act, wsel, sus_in, mac_out, out_ready,
        output in_ready, rwlb_row0, rwlb_row1, sus, out_valid, out_data
    );

    modport master (
        output in_valid, act, wsel, sus_in, mac_out, out_ready,
        input  in_ready, rwlb_row0, rwlb_row1, sus, out_valid, out_data
    );
endinterface

// File: rtl/cim_input_driver.sv
// Bit-serial activation driver for one MAC column: streams activations LSB-first
// onto active-low read wordlines and shift-accumulates the column result.
module cim_input_driver #(
    parameter int IN_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    cim_input_driver_if.slave   bus
);
    localparam int ACC_W = 15 + IN_BITS;
    localparam int K_W   = $clog2(IN_BITS);
    localparam logic [K_W-1:0] K_LAST = K_W'(IN_BITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [K_W-1:0]         k;
    logic [ACC_W-1:0]       acc;
    logic [8*IN_BITS-1:0]   act_q;
    logic [7:0]             wsel_q;

    logic [7:0]             lsb_in;
    logic [7:0]             lsb_q;
    logic [8*IN_BITS-1:0]   act_in_shr;
    logic [8*IN_BITS-1:0]   act_q_shr;
    logic [ACC_W-1:0]       m;
    logic [ACC_W-1:0]       shifted;
    logic [ACC_W-1:0]       acc_next;

    // Each lane is kept as a right-shifting register so the next bit is always its LSB.
    always_comb begin
        lsb_in     = '0;
        lsb_q      = '0;
        act_in_shr = '0;
        act_q_shr  = '0;
        for (int i = 0; i < 8; i++) begin
            lsb_in[i] = bus.act[i*IN_BITS];
            lsb_q[i]  = act_q[i*IN_BITS];
            act_in_shr[i*IN_BITS +: IN_BITS] = bus.act[i*IN_BITS +: IN_BITS] >> 1;
            act_q_shr[i*IN_BITS +: IN_BITS]  = act_q[i*IN_BITS +: IN_BITS] >> 1;
        end
    end

    // The activation sign bit carries negative weight, so the last signed sample is subtracted.
    always_comb begin
        m        = bus.sus ? {{(ACC_W-15){bus.mac_out[14]}}, bus.mac_out}
                           : {{(ACC_W-15){1'b0}}, bus.mac_out};
        shifted  = m << k;
        acc_next = (bus.sus && (k == K_LAST)) ? (acc - shifted) : (acc + shifted);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            k             <= '0;
            acc           <= '0;
            act_q         <= '0;
            wsel_q        <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.rwlb_row0 <= 8'hFF;
            bus.rwlb_row1 <= 8'hFF;
            bus.sus       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        act_q         <= act_in_shr;
                        wsel_q        <= bus.wsel;
                        bus.sus       <= bus.sus_in;
                        acc           <= '0;
                        k             <= '0;
                        bus.rwlb_row0 <= ~(lsb_in & ~bus.wsel);
                        bus.rwlb_row1 <= ~(lsb_in & bus.wsel);
                        bus.in_ready  <= 1'b0;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (k == K_LAST) begin
                        bus.rwlb_row0 <= 8'hFF;
                        bus.rwlb_row1 <= 8'hFF;
                        bus.out_data  <= acc_next;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        k             <= k + 1'b1;
                        act_q         <= act_q_shr;
                        bus.rwlb_row0 <= ~(lsb_q & ~wsel_q);
                        bus.rwlb_row1 <= ~(lsb_q & wsel_q);
                    end
                end
                DONE: begin
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cim_input_driver.sv
// Scoreboard bench for cim_input_driver with a behavioural MAC column model:
// mac_out = gain * (number of wordlines driven low) + offset.
module tb_cim_input_driver;
    localparam int IN_BITS = 8;
    localparam int ACC_W   = 15 + IN_BITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cim_input_driver_if #(.IN_BITS(IN_BITS)) bus ();

    cim_input_driver #(.IN_BITS(IN_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int gain   = 5;
    int offset = 0;
    int n_checks = 0;
    int n_pass   = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [7:0] both_low;

    always_comb begin
        bus.mac_out = 15'(gain * ($countones(~bus.rwlb_row0) + $countones(~bus.rwlb_row1)) + offset);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Result monitor: pops the scoreboard on every accepted result.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", bus.out_data);
            end else begin
                checkOutput("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            both_low = ~bus.rwlb_row0 & ~bus.rwlb_row1;
            checkOutput("no_dual_row", 32'(both_low), 32'd0);
        end
    end

    task automatic applyStimulus(input logic [8*IN_BITS-1:0] a, input logic [7:0] w,
                                 input logic s, input logic [ACC_W-1:0] expected);
        bit accepted = 0;
        bus.in_valid = 1'b1;
        bus.act      = a;
        bus.wsel     = w;
        bus.sus_in   = s;
        for (int i = 0; i < 60 && !accepted; i++) begin
            @(negedge clk);
            if (bus.in_ready) accepted = 1;
        end
        if (accepted) exp_q.push_back(expected);
        else checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.act       = '0;
        bus.wsel      = '0;
        bus.sus_in    = 1'b0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("reset_row0", 32'(bus.rwlb_row0), 32'hFF);
        checkOutput("reset_row1", 32'(bus.rwlb_row1), 32'hFF);
        checkOutput("reset_sus", 32'(bus.sus), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned, all lanes 3: two active bit-cycles of 40 -> 40 + 80.
        bus.out_ready = 1'b1;
        applyStimulus({8{8'd3}}, 8'h00, 1'b0, 23'd120);
        for (int k = 0; k < IN_BITS; k++) begin
            @(negedge clk);
            checkOutput("t1_row0", 32'(bus.rwlb_row0), (k < 2) ? 32'h00 : 32'hFF);
            checkOutput("t1_row1", 32'(bus.rwlb_row1), 32'hFF);
            checkOutput("t1_out_valid_run", 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);
        checkOutput("t1_out_valid_latency", 32'(bus.out_valid), 32'd1);
        waitDrain();

        // Signed, all lanes -1: 40*127 - 40*128; sus_in flips after accept.
        applyStimulus({8{8'hFF}}, 8'h00, 1'b1, 23'(-40));
        bus.sus_in = 1'b0;
        @(negedge clk);
        checkOutput("t2_sus_latched", 32'(bus.sus), 32'd1);
        waitDrain();

        // Signed, all lanes 2, negative column result -40 at k=1.
        gain = -5;
        applyStimulus({8{8'd2}}, 8'h00, 1'b1, 23'(-80));
        waitDrain();
        gain = 5;

        // Row-1 selection, single active lane for one bit-cycle.
        applyStimulus({56'd0, 8'd1}, 8'hFF, 1'b0, 23'd5);
        for (int k = 0; k < IN_BITS; k++) begin
            @(negedge clk);
            checkOutput("t4_row1", 32'(bus.rwlb_row1), (k == 0) ? 32'hFE : 32'hFF);
            checkOutput("t4_row0", 32'(bus.rwlb_row0), 32'hFF);
        end
        waitDrain();

        // All-zero activations: idle offset 7 accumulated over every bit weight.
        offset = 7;
        applyStimulus('0, 8'h3C, 1'b0, 23'd1785);
        waitDrain();
        offset = 0;

        // Backpressure in DONE while a second job is held on the input.
        bus.out_ready = 1'b0;
        applyStimulus({8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 8'h0F, 1'b0, 23'd1800);
        for (int i = 0; i < 30 && !bus.out_valid; i++) @(negedge clk);
        checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.act      = {8{8'd1}};
        bus.wsel     = 8'h00;
        bus.sus_in   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_out_data_stable", 32'(bus.out_data), 32'd1800);
            checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        exp_q.push_back(23'd40);
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        waitDrain();

        // Reset pulse at k = 3 discards the job.
        applyStimulus({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'h00, 1'b0, 23'd180);
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_row0", 32'(bus.rwlb_row0), 32'hFF);
        checkOutput("rst_row1", 32'(bus.rwlb_row1), 32'hFF);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("rst_no_result", 32'(bus.out_valid), 32'd0);
        applyStimulus({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'hA5, 1'b0, 23'd180);
        waitDrain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
